uart_tx_engine: RTL

UART_TX_ENGINE -- requirements
Module: uart_tx_engine

---
 rtl/uart_tx_engine_if.sv | 9 +
 rtl/uart_tx_engine.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_engine_if.sv
// TX FIFO read port between the UART transmit engine (master) and its FIFO (slave).
interface uart_tx_engine_if;
    logic       fifo_empty;
    logic [7:0] fifo_rdata;
    logic       fifo_rd;

    modport master (input fifo_empty, input fifo_rdata, output fifo_rd);
    modport slave  (output fifo_empty, output fifo_rdata, input fifo_rd);
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: pulls bytes from a TX FIFO through a holding register and
// serialises them with configurable data length, parity and stop bits, one bit per baud_tick.
module uart_tx_engine (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              baud_tick,
    input  logic              TXen,
    input  logic [3:0]        data_bits,
    input  logic              parity_en,
    input  logic              parity_odd,
    input  logic              stop_bit_twice,
    uart_tx_engine_if.master  fifo,
    output logic              txd,
    output logic              tx_busy,
    output logic              tx_done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP_0 = 3'd4,
        STOP_1 = 3'd5
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] hold_r;
    logic       hold_valid_r;
    logic [7:0] shift_r;
    logic [2:0] cnt_r;
    logic [2:0] cnt_next_s;
    logic [2:0] last_r;
    logic       par_en_r;
    logic       par_odd_r;
    logic       stop2_r;
    logic       rd_r;
    logic       cap_r;
    logic       rd_req_s;
    logic       launch_s;
    logic       frame_end_s;
    logic       txd_r;
    logic       txd_next_s;
    logic       busy_r;
    logic       busy_next_s;
    logic       done_r;

    // Index of the last data bit: lengths below 5 act as 5, above 8 act as 8.
    function automatic logic [2:0] last_index(input logic [3:0] bits);
        logic [2:0] idx;
        if (bits < 4'd5) begin
            idx = 3'd4;
        end else if (bits > 4'd8) begin
            idx = 3'd7;
        end else begin
            idx = bits[2:0] - 3'd1;
        end
        return idx;
    endfunction

    function automatic logic frame_parity(input logic [7:0] data, input logic [2:0] last,
                                          input logic odd);
        logic p;
        p = odd;
        for (int i = 0; i < 8; i++) begin
            if (i <= int'(last)) begin
                p = p ^ data[i];
            end else begin
                p = p;
            end
        end
        return p;
    endfunction

    // Next-state decision; the frame only advances on baud ticks.
    always_comb begin
        state_next_s = state_r;
        frame_end_s  = 1'b0;
        if (baud_tick) begin
            case (state_r)
                IDLE: begin
                    if (hold_valid_r && TXen) state_next_s = START;
                    else                      state_next_s = IDLE;
                end
                START:  state_next_s = DATA;
                DATA: begin
                    if (cnt_r != last_r) state_next_s = DATA;
                    else if (par_en_r)   state_next_s = PARITY;
                    else                 state_next_s = STOP_0;
                end
                PARITY: state_next_s = STOP_0;
                STOP_0: begin
                    if (stop2_r) begin
                        state_next_s = STOP_1;
                    end else begin
                        frame_end_s  = 1'b1;
                        state_next_s = (hold_valid_r && TXen) ? START : IDLE;
                    end
                end
                STOP_1: begin
                    frame_end_s  = 1'b1;
                    state_next_s = (hold_valid_r && TXen) ? START : IDLE;
                end
                default: state_next_s = IDLE;
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // Output values for the next cycle, plus launch/read strobes and the bit counter.
    always_comb begin
        launch_s    = baud_tick && (state_next_s == START);
        rd_req_s    = TXen && !fifo.fifo_empty && !hold_valid_r && !rd_r && !cap_r;
        cnt_next_s  = cnt_r;
        if (baud_tick && (state_r == START)) begin
            cnt_next_s = 3'd0;
        end else if (baud_tick && (state_r == DATA)) begin
            cnt_next_s = cnt_r + 3'd1;
        end else begin
            cnt_next_s = cnt_r;
        end
        busy_next_s = (state_next_s != IDLE);
        txd_next_s  = 1'b1;
        case (state_next_s)
            START:   txd_next_s = 1'b0;
            DATA:    txd_next_s = shift_r[cnt_next_s];
            PARITY:  txd_next_s = frame_parity(shift_r, last_r, par_odd_r);
            default: txd_next_s = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Holding register; cap_r marks the cycle the FIFO's read data is valid.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            hold_r       <= 8'd0;
            hold_valid_r <= 1'b0;
            rd_r         <= 1'b0;
            cap_r        <= 1'b0;
        end else begin
            rd_r  <= rd_req_s;
            cap_r <= rd_r;
            if (cap_r) begin
                hold_r       <= fifo.fifo_rdata;
                hold_valid_r <= 1'b1;
            end else if (launch_s) begin
                hold_valid_r <= 1'b0;
            end else begin
                hold_r       <= hold_r;
                hold_valid_r <= hold_valid_r;
            end
        end
    end

    // Frame datapath: configuration is captured once per frame at launch.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            shift_r   <= 8'd0;
            cnt_r     <= 3'd0;
            last_r    <= 3'd7;
            par_en_r  <= 1'b0;
            par_odd_r <= 1'b0;
            stop2_r   <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            if (launch_s) begin
                shift_r   <= hold_r;
                last_r    <= last_index(data_bits);
                par_en_r  <= parity_en;
                par_odd_r <= parity_odd;
                stop2_r   <= stop_bit_twice;
            end else begin
                shift_r   <= shift_r;
                last_r    <= last_r;
                par_en_r  <= par_en_r;
                par_odd_r <= par_odd_r;
                stop2_r   <= stop2_r;
            end
        end
    end

    // Registered serial line and status outputs.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            txd_r  <= 1'b1;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            txd_r  <= txd_next_s;
            busy_r <= busy_next_s;
            done_r <= frame_end_s;
        end
    end

    assign txd          = txd_r;
    assign tx_busy      = busy_r;
    assign tx_done      = done_r;
    assign fifo.fifo_rd = rd_r;

endmodule
